pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the branch-target LUT.
- Holds the 10-bit PC and selects the next PC each cycle: sequential increment, absolute branch to the LUT target, or relative jump by a signed offset.
- Runs a small run-control FSM (idle/run/halted) that gates instruction fetch and reports completion to the testbench.

Parameters:
- D, 10, PC width in bits; all PC arithmetic is modulo 2**D.
- START_ADDR, 0, PC value loaded on reset and on every start.
- STACK_DEPTH, 4, return-stack entries; used only with PC_RET_STACK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins execution.
- stall  in  1  hold the PC this cycle.
- halt_req  in  1  stop execution after the current instruction.
- branch_en  in  1  current instruction is an absolute branch.
- branch_cond  in  1  branch condition; a branch is taken when branch_en & branch_cond.
- target  in  D  absolute target from the LUT.
- rel_en  in  1  relative jump.
- rel_off  in  D  two's-complement offset.
- call_en  in  1  call to target (feature only).
- ret_en  in  1  return (feature only).
- prog_ctr  out  D  current PC, registered.
- running  out  1  FSM is in RUN.
- done  out  1  FSM is in HALTED.
- stack_err  out  1  sticky return-stack over/underflow flag.

Behaviour:
- Reset (asynchronous, rst_n=0): prog_ctr=START_ADDR, state=IDLE, running=0, done=0, stack_err=0, stack emptied. Outputs hold while rst_n is low. Reset mid-run aborts immediately.
- IDLE: PC is held at START_ADDR. On start, go to RUN; prog_ctr stays START_ADDR for the first RUN cycle.
- RUN, per-cycle priority, highest first:
  - halt_req: go to HALTED; PC is held.
  - stall: PC is held; all other controls are ignored.
  - ret_en (feature only): PC = popped value.
  - call_en (feature only): push PC+1; PC = target.
  - branch taken: PC = target.
  - rel_en: PC = (PC + rel_off) mod 2**D.
  - Otherwise: PC = PC + 1.
- Next-PC latency: one cycle. The value is visible on prog_ctr the cycle after the controls are sampled.
- Arithmetic: D-bit add with the carry discarded.
  - PC = 2**D-1 with increment gives 0.
  - PC=4 with rel_off=all-ones gives 3.
  - PC=1020 with rel_off=+20 gives 16.
- branch_en with branch_cond=0 falls through to rel_en, then to increment.
- branch_en and rel_en both asserted: the branch takes precedence.
- start while in RUN is ignored.
- HALTED: done=1 and the PC is held. start reloads START_ADDR, clears done and goes to RUN. halt_req in HALTED is ignored.
- start and halt_req in the same cycle:
  - In IDLE, start wins.
  - In RUN, halt_req wins.

Optional Feature:
- PC_RET_STACK_EN defined:
  - Adds a STACK_DEPTH-entry LIFO of D-bit return addresses.
  - Push when full overwrites the oldest entry and sets stack_err.
  - Pop when empty loads START_ADDR and sets stack_err.
  - stack_err is sticky until reset or start.
  - call_en and ret_en in the same cycle: ret_en wins and no push occurs.
- PC_RET_STACK_EN undefined:
  - call_en and ret_en are ignored.
  - stack_err is tied to 0.
  - No stack storage is built.

Decomposition:
- Package pc_pkg holds:
  - the state typedef enum {IDLE, RUN, HALTED};
  - localparam PC_W=10;
  - the START_ADDR default;
  - the next-PC select typedef {SEL_HOLD, SEL_INC, SEL_ABS, SEL_REL, SEL_RET}.
- Sub-module pc_ret_stack contains the LUT-independent LIFO with push, pop, full, empty and a data port. It is instantiated only under PC_RET_STACK_EN.

Test Plan:
- Reset then start; run 5 cycles with no controls -> prog_ctr 0,0,1,2,3; running=1.
- At PC=5: branch_en=1, branch_cond=1, target=83 -> next PC 83. Same controls with branch_cond=0 -> next PC 6.
- At PC=4: rel_en, rel_off=10'h3FF -> 3. At PC=1020: rel_off=20 -> 16. At PC=1023 with increment -> 0.
- At PC=44: stall held for 3 cycles with branch_en asserted -> PC stays 44. Then halt_req -> done=1 and PC stays 44. Then start -> PC 0 and running=1.
- rst_n pulsed low mid-run at PC=107 -> prog_ctr=0, IDLE and done=0 immediately, with no clock edge required.
- PC_RET_STACK_EN defined:
  - call at PC=10 to target 90, then ret -> PC 11.
  - Five nested calls -> stack_err=1.
  - ret on an empty stack -> PC 0 and stack_err=1.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the program-counter sequencer
package pc_pkg;

  localparam int PC_W           = 10;
  localparam int START_ADDR_DEF = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_ABS,
    SEL_REL,
    SEL_RET
  } pc_sel_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control and status bundle between the LUT stage and the PC sequencer
interface pc_sequencer_if import pc_pkg::*; #(
  parameter int D = PC_W
);

  logic         start;
  logic         stall;
  logic         halt_req;
  logic         branch_en;
  logic         branch_cond;
  logic [D-1:0] target;
  logic         rel_en;
  logic [D-1:0] rel_off;
  logic         call_en;
  logic         ret_en;
  logic [D-1:0] prog_ctr;
  logic         running;
  logic         done;
  logic         stack_err;

  modport master (
    output start, stall, halt_req, branch_en, branch_cond, target,
           rel_en, rel_off, call_en, ret_en,
    input  prog_ctr, running, done, stack_err
  );

  modport slave (
    input  start, stall, halt_req, branch_en, branch_cond, target,
           rel_en, rel_off, call_en, ret_en,
    output prog_ctr, running, done, stack_err
  );

endinterface

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - circular LIFO of return addresses; a push when full overwrites the oldest entry
module pc_ret_stack #(
  parameter int D     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [D-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top;
  logic [PW-1:0] nxt;
  logic [CW-1:0] count;

  // ptr is the next free slot; once full it also points at the oldest entry
  assign top      = (ptr == '0)   ? LAST : ptr - PW'(1);
  assign nxt      = (ptr == LAST) ? '0   : ptr + PW'(1);
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_data = mem[top];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (pop) begin
      if (!empty) begin
        ptr   <= top;
        count <= count - CW'(1);
      end
    end else if (push) begin
      ptr <= nxt;
      if (!full) count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop && !flush) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register with run-control FSM; return stack under PC_RET_STACK_EN
module pc_sequencer import pc_pkg::*; #(
  parameter int          D           = PC_W,
  parameter int unsigned START_ADDR  = START_ADDR_DEF,
  parameter int          STACK_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  localparam logic [D-1:0] START_PC = START_ADDR[D-1:0];

  state_t       state_q;
  state_t       state_d;
  pc_sel_t      sel;
  logic [D-1:0] pc_q;
  logic [D-1:0] pc_d;
  logic [D-1:0] ret_pc;
  logic         load_start;
  logic         branch_taken;

`ifdef PC_RET_STACK_EN
  logic         push;
  logic         pop;
`endif

  assign branch_taken = bus.branch_en & bus.branch_cond;

  always_comb begin
    state_d    = state_q;
    sel        = SEL_HOLD;
    load_start = 1'b0;
`ifdef PC_RET_STACK_EN
    push       = 1'b0;
    pop        = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RUN;
          load_start = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d = HALTED;
        end else if (bus.stall) begin
          sel = SEL_HOLD;
`ifdef PC_RET_STACK_EN
        end else if (bus.ret_en) begin
          sel = SEL_RET;
          pop = 1'b1;
        end else if (bus.call_en) begin
          sel  = SEL_ABS;
          push = 1'b1;
`endif
        end else if (branch_taken) begin
          sel = SEL_ABS;
        end else if (bus.rel_en) begin
          sel = SEL_REL;
        end else begin
          sel = SEL_INC;
        end
      end
      HALTED: begin
        if (bus.start) begin
          state_d    = RUN;
          load_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (sel)
      SEL_INC: pc_d = pc_q + D'(1);
      SEL_ABS: pc_d = bus.target;
      SEL_REL: pc_d = pc_q + bus.rel_off;
      SEL_RET: pc_d = ret_pc;
      default: pc_d = pc_q;
    endcase
    if (load_start) pc_d = START_PC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.prog_ctr = pc_q;
  assign bus.running  = (state_q == RUN);
  assign bus.done     = (state_q == HALTED);

`ifdef PC_RET_STACK_EN
  logic [D-1:0] pop_data;
  logic         stack_full;
  logic         stack_empty;
  logic         err_q;

  pc_ret_stack #(
    .D     (D),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (load_start),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q + D'(1)),
    .pop_data  (pop_data),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // an underflowing return restarts the program rather than jumping to stale data
  assign ret_pc = stack_empty ? START_PC : pop_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (load_start) begin
      err_q <= 1'b0;
    end else if ((push && stack_full) || (pop && stack_empty)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.stack_err = err_q;
`else
  localparam int unused_stack_depth = STACK_DEPTH;
  logic unused_stack_ctrl;

  assign unused_stack_ctrl = bus.call_en ^ bus.ret_en;
  assign ret_pc            = START_PC;
  assign bus.stack_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_sequencer_if #(.D(10)) bus ();

  pc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.stall       = 1'b0;
    bus.halt_req    = 1'b0;
    bus.branch_en   = 1'b0;
    bus.branch_cond = 1'b0;
    bus.target      = '0;
    bus.rel_en      = 1'b0;
    bus.rel_off     = '0;
    bus.call_en     = 1'b0;
    bus.ret_en      = 1'b0;
  endtask

  task automatic jump_to(input logic [9:0] addr);
    bus.branch_en   = 1'b1;
    bus.branch_cond = 1'b1;
    bus.target      = addr;
    step();
    bus.branch_en   = 1'b0;
    bus.branch_cond = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (bus.prog_ctr !== 10'd0) begin
      errors++; $display("FAIL reset_pc: got %0d expected 0", bus.prog_ctr);
    end
    checks++;
    if ({bus.running, bus.done, bus.stack_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {bus.running, bus.done, bus.stack_err});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.running, bus.prog_ctr} !== {1'b0, 10'd0}) begin
      errors++; $display("FAIL idle_hold: running=%b pc=%0d expected running=0 pc=0", bus.running, bus.prog_ctr);
    end
  endtask

  task automatic test_sequential();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.running, bus.prog_ctr} !== {1'b1, 10'd0}) begin
      errors++; $display("FAIL first_run: running=%b pc=%0d expected running=1 pc=0", bus.running, bus.prog_ctr);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (bus.prog_ctr !== 10'(i)) begin
        errors++; $display("FAIL seq_inc: got %0d expected %0d", bus.prog_ctr, i);
      end
    end
    step();
    step();
    checks++;
    if (bus.prog_ctr !== 10'd5) begin
      errors++; $display("FAIL seq_to_5: got %0d expected 5", bus.prog_ctr);
    end
  endtask

  task automatic test_branch();
    jump_to(10'd83);
    checks++;
    if (bus.prog_ctr !== 10'd83) begin
      errors++; $display("FAIL branch_taken: got %0d expected 83", bus.prog_ctr);
    end
    jump_to(10'd5);
    bus.branch_en   = 1'b1;
    bus.branch_cond = 1'b0;
    bus.target      = 10'd83;
    step();
    checks++;
    if (bus.prog_ctr !== 10'd6) begin
      errors++; $display("FAIL branch_not_taken: got %0d expected 6", bus.prog_ctr);
    end
    bus.rel_en  = 1'b1;
    bus.rel_off = 10'd2;
    step();
    checks++;
    if (bus.prog_ctr !== 10'd8) begin
      errors++; $display("FAIL cond0_falls_to_rel: got %0d expected 8", bus.prog_ctr);
    end
    bus.branch_cond = 1'b1;
    bus.target      = 10'd4;
    step();
    checks++;
    if (bus.prog_ctr !== 10'd4) begin
      errors++; $display("FAIL branch_over_rel: got %0d expected 4", bus.prog_ctr);
    end
    idle_inputs();
  endtask

  task automatic test_rel();
    bus.rel_en  = 1'b1;
    bus.rel_off = 10'h3FF;
    step();
    bus.rel_en  = 1'b0;
    checks++;
    if (bus.prog_ctr !== 10'd3) begin
      errors++; $display("FAIL rel_minus1: got %0d expected 3", bus.prog_ctr);
    end
    jump_to(10'd1020);
    bus.rel_en  = 1'b1;
    bus.rel_off = 10'd20;
    step();
    bus.rel_en  = 1'b0;
    checks++;
    if (bus.prog_ctr !== 10'd16) begin
      errors++; $display("FAIL rel_wrap: got %0d expected 16", bus.prog_ctr);
    end
    jump_to(10'd1023);
    step();
    checks++;
    if (bus.prog_ctr !== 10'd0) begin
      errors++; $display("FAIL inc_wrap: got %0d expected 0", bus.prog_ctr);
    end
  endtask

  task automatic test_stall_halt();
    jump_to(10'd44);
    bus.stall       = 1'b1;
    bus.branch_en   = 1'b1;
    bus.branch_cond = 1'b1;
    bus.target      = 10'd83;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.prog_ctr !== 10'd44) begin
        errors++; $display("FAIL stall_hold: cycle %0d got %0d expected 44", i, bus.prog_ctr);
      end
    end
    idle_inputs();
    bus.halt_req = 1'b1;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.done, bus.running, bus.prog_ctr} !== {1'b1, 1'b0, 10'd44}) begin
      errors++; $display("FAIL halt_wins_in_run: done=%b running=%b pc=%0d expected done=1 running=0 pc=44", bus.done, bus.running, bus.prog_ctr);
    end
    step();
    step();
    checks++;
    if ({bus.done, bus.prog_ctr} !== {1'b1, 10'd44}) begin
      errors++; $display("FAIL halted_hold: done=%b pc=%0d expected done=1 pc=44", bus.done, bus.prog_ctr);
    end
    bus.halt_req = 1'b0;
    bus.start    = 1'b1;
    step();
    checks++;
    if ({bus.done, bus.running, bus.prog_ctr} !== {1'b0, 1'b1, 10'd0}) begin
      errors++; $display("FAIL restart: done=%b running=%b pc=%0d expected done=0 running=1 pc=0", bus.done, bus.running, bus.prog_ctr);
    end
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.running, bus.prog_ctr} !== {1'b1, 10'd1}) begin
      errors++; $display("FAIL start_in_run: running=%b pc=%0d expected running=1 pc=1", bus.running, bus.prog_ctr);
    end
  endtask

  task automatic test_async_reset();
    jump_to(10'd107);
    checks++;
    if (bus.prog_ctr !== 10'd107) begin
      errors++; $display("FAIL pre_reset_pc: got %0d expected 107", bus.prog_ctr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.running, bus.done, bus.prog_ctr} !== {1'b0, 1'b0, 10'd0}) begin
      errors++; $display("FAIL async_reset: running=%b done=%b pc=%0d expected 0 0 0", bus.running, bus.done, bus.prog_ctr);
    end
    step();
    rst_n = 1'b1;
    step();
    bus.start    = 1'b1;
    bus.halt_req = 1'b1;
    step();
    idle_inputs();
    checks++;
    if ({bus.running, bus.done, bus.prog_ctr} !== {1'b1, 1'b0, 10'd0}) begin
      errors++; $display("FAIL start_wins_in_idle: running=%b done=%b pc=%0d expected 1 0 0", bus.running, bus.done, bus.prog_ctr);
    end
  endtask

`ifdef PC_RET_STACK_EN
  task automatic test_stack();
    jump_to(10'd10);
    bus.call_en = 1'b1;
    bus.target  = 10'd90;
    step();
    bus.call_en = 1'b0;
    checks++;
    if (bus.prog_ctr !== 10'd90) begin
      errors++; $display("FAIL call: got %0d expected 90", bus.prog_ctr);
    end
    bus.ret_en = 1'b1;
    step();
    bus.ret_en = 1'b0;
    checks++;
    if ({bus.stack_err, bus.prog_ctr} !== {1'b0, 10'd11}) begin
      errors++; $display("FAIL ret: err=%b pc=%0d expected err=0 pc=11", bus.stack_err, bus.prog_ctr);
    end
    bus.call_en = 1'b1;
    step();
    bus.ret_en = 1'b1;
    bus.target = 10'd300;
    step();
    bus.call_en = 1'b0;
    checks++;
    if (bus.prog_ctr !== 10'd12) begin
      errors++; $display("FAIL ret_over_call: got %0d expected 12", bus.prog_ctr);
    end
    step();
    bus.ret_en = 1'b0;
    checks++;
    if ({bus.stack_err, bus.prog_ctr} !== {1'b1, 10'd0}) begin
      errors++; $display("FAIL underflow: err=%b pc=%0d expected err=1 pc=0", bus.stack_err, bus.prog_ctr);
    end
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.stack_err !== 1'b0) begin
      errors++; $display("FAIL err_clear_on_start: got %b expected 0", bus.stack_err);
    end
    bus.call_en = 1'b1;
    bus.target  = 10'd200;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.stack_err !== 1'b0) begin
      errors++; $display("FAIL four_calls_no_err: got %b expected 0", bus.stack_err);
    end
    step();
    bus.call_en = 1'b0;
    checks++;
    if (bus.stack_err !== 1'b1) begin
      errors++; $display("FAIL overflow: got %b expected 1", bus.stack_err);
    end
    bus.ret_en = 1'b1;
    step();
    bus.ret_en = 1'b0;
    checks++;
    if (bus.prog_ctr !== 10'd201) begin
      errors++; $display("FAIL ret_after_overflow: got %0d expected 201", bus.prog_ctr);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_rel();
    test_stall_halt();
    test_async_reset();
`ifdef PC_RET_STACK_EN
    test_stack();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
